uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
- REQ-001 Parameter: NREQ, default 4, number of requesters (2..8).
- REQ-002 Parameter: TMO_CYC, default 255, start-timeout limit in clk16x cycles (1..255).
- REQ-003 Port: clk16x  in  1  sole clock; all state updates on its rising edge.
- REQ-004 Port: clr  in  1  reset; synchronous, active-high.
- REQ-005 Port: req  in  NREQ  per-requester send request; held high until ack.
- REQ-006 Port: req_data  in  8*NREQ  byte of requester i on bits [8i+7:8i]; stable while req[i] high.
- REQ-007 Port: ack  out  NREQ  one-cycle pulse; byte of requester i accepted.
- REQ-008 Port: tx_wrn  out  1  active-low write strobe to the UART transmitter.
- REQ-009 Port: tx_data  out  8  byte presented to the transmitter.
- REQ-010 Port: tx_busy  in  1  transmitter busy: buffer loaded or frame shifting.
- REQ-011 Port: grant_id  out  3  index of the current or last granted requester.
- REQ-012 Port: busy  out  1  high in any state other than IDLE.
- REQ-013 Port: tmo_err  out  1  sticky start-timeout flag (see REQ-030).

Function
- REQ-014 FSM states: IDLE, WRITE, WAIT_START, WAIT_DONE; state register is 2 bits.
- REQ-015 IDLE with no req bit high: remain in IDLE; tx_wrn=1; ack=0.
- REQ-016 IDLE with any req bit high: grant the first requester with req high, searching round-robin from (last_grant+1) mod NREQ; latch req_data of that requester into tx_data; set grant_id; next state WRITE.
- REQ-017 WRITE: tx_wrn=0 and ack[grant_id]=1 for exactly this one cycle; next state WAIT_START.
- REQ-018 WAIT_START: tx_busy=1 -> WAIT_DONE; otherwise remain.
- REQ-019 WAIT_DONE: tx_busy=0 -> IDLE; otherwise remain.
- REQ-020 Latency: req rising in IDLE at edge N produces tx_wrn low and ack during cycle N+1.
- REQ-021 At most one ack bit is high in any cycle; ack is never high outside WRITE.
- REQ-022 tx_data holds the latched byte from WRITE until the next grant; it is unaffected by req_data changes.
- REQ-023 last_grant updates only on a grant; after reset the search starts at requester 0.
- REQ-024 A requester that holds req high after its ack is re-arbitrated at the next IDLE; any other pending requester wins first (fairness).
- REQ-025 All NREQ requests high continuously: grants rotate 0,1,..,NREQ-1,0,...
- REQ-026 req bits change during WRITE, WAIT_START or WAIT_DONE: ignored until IDLE.
- REQ-027 tx_busy already high on entry to WAIT_START: exits to WAIT_DONE on the next edge.
- REQ-028 req bits at positions >= NREQ do not exist; grant_id < NREQ always.

Reset
- REQ-029 clr=1 at an edge: state=IDLE; tx_wrn=1; ack=0; tx_data=8'h00; grant_id=0; last_grant=NREQ-1; busy=0; tmo_err=0; timeout counter=0. This applies mid-transfer; an in-flight ack pulse is cancelled on the following cycle.

Configuration
- REQ-030 Macro UART_TX_SCHED_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT_START and increments each cycle in WAIT_START; when it reaches TMO_CYC with tx_busy still 0, the FSM returns to IDLE and tmo_err sets. tmo_err stays set until clr.
- REQ-031 Macro UART_TX_SCHED_TIMEOUT_EN undefined: no counter is present; WAIT_START waits indefinitely; tmo_err is tied to 0.

Verification
- REQ-032 Single request: req=4'b0100, data2=8'hA5 -> one cycle later tx_wrn=0, ack=4'b0100, tx_data=8'hA5, grant_id=2; tx_busy pulse of 20 cycles -> back to IDLE, busy=0.
- REQ-033 Round-robin: req=4'b1111 held, tx_busy model 10 cycles per byte -> ack order 0,1,2,3,0; one ack per transfer.
- REQ-034 Fairness: req0 held high, req3 raised during requester 0's WAIT_DONE -> next grant goes to 3, then to 0.
- REQ-035 Reset mid-transfer: clr=1 during WAIT_DONE with tx_busy=1 -> next cycle state=IDLE, tx_wrn=1, grant_id=0; first post-reset grant with req=4'b1001 goes to 0.
- REQ-036 Timeout (macro defined, TMO_CYC=16): tx_busy held 0 after WRITE -> FSM back in IDLE after 16 WAIT_START cycles, tmo_err=1; it stays 1 across later transfers until clr.
- REQ-037 Stable data: req_data toggled every cycle during WAIT_DONE -> tx_data keeps the latched value.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that feeds bytes from NREQ requesters into a single UART transmitter.
// Optional start-timeout watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk16x,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              tx_wrn,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              tmo_err
);

  localparam int unsigned IDW = 3;
  localparam int unsigned CW  = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_sched: NREQ must be in 2..8");
  end
  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
    $error("uart_tx_sched: TMO_CYC must be in 1..255");
  end

  state_t         state;
  state_t         state_n;
  logic [IDW-1:0] last_grant;
  logic [7:0]     req_pad;
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [7:0]     pick_data;
  logic           grant;
  logic           tmo_hit;

  // Pad to 8 lanes so a 3-bit index never runs past the vector.
  assign req_pad = 8'(req);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!pick_valid && req_pad[IDW'((32'(last_grant) + k) % NREQ)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'((32'(last_grant) + k) % NREQ);
      end
    end
  end

  // Byte lane of the winning requester.
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) pick_data = req_data[8*i +: 8];
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = WRITE;
          grant   = 1'b1;
        end
      end
      WRITE:      state_n = WAIT_START;
      WAIT_START: begin
        if (tx_busy)      state_n = WAIT_DONE;
        else if (tmo_hit) state_n = IDLE;
      end
      WAIT_DONE:  if (!tx_busy) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // State register and registered outputs, derived from the next state.
  always_ff @(posedge clk16x) begin
    if (clr) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      grant_id   <= '0;
      tx_data    <= '0;
      tx_wrn     <= 1'b1;
      ack        <= '0;
      busy       <= 1'b0;
    end else begin
      state  <= state_n;
      tx_wrn <= (state_n != WRITE);
      busy   <= (state_n != IDLE);
      if (grant) begin
        last_grant <= pick_idx;
        grant_id   <= pick_idx;
        tx_data    <= pick_data;
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        ack[i] <= grant && (pick_idx == IDW'(i));
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [CW-1:0] tmo_cnt;

  // Counter is held at zero outside WAIT_START, so it starts from zero on every entry.
  assign tmo_hit = (state == WAIT_START) && !tx_busy && (tmo_cnt == CW'(TMO_CYC - 1));

  always_ff @(posedge clk16x) begin
    if (clr) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state != WAIT_START) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) tmo_err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table plus hand-written corner sequences,
// with a scoreboard of expected grants checked whenever ack pulses.
module tb_uart_tx_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TMO  = 16;

  logic            clk16x;
  logic            clr;
  logic [3:0]      req;
  logic [31:0]     req_data;
  logic [3:0]      ack;
  logic            tx_wrn;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [2:0]      grant_id;
  logic            busy;
  logic            tmo_err;

  uart_tx_sched #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
    .clk16x   (clk16x),
    .clr      (clr),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .tx_wrn   (tx_wrn),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .busy     (busy),
    .tmo_err  (tmo_err)
  );

  initial clk16x = 1'b0;
  always #5 clk16x = ~clk16x;

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] word;
    logic [2:0]  id;
    logic [7:0]  data;
    int          lag;
    int          blen;
    bit          toggle;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest expected grant.
  always @(negedge clk16x) begin
    if (mon_en) begin
      chk("wrn_vs_ack", 32'(tx_wrn), 32'(ack == 4'b0000));
      if (ack != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_vec",       32'(ack),      32'(4'b0001 << e.id));
          chk("grant_id",      32'(grant_id), 32'(e.id));
          chk("tx_data",       32'(tx_data),  32'(e.data));
          chk("busy_in_write", 32'(busy),     32'd1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk16x);
    clr     = 1'b1;
    req     = 4'b0000;
    tx_busy = 1'b0;
    @(negedge clk16x);
    clr = 1'b0;
    chk("sb_empty_at_reset", 32'(sb.size()), 32'd0);
    sb.delete();
    chk("rst_tx_wrn",   32'(tx_wrn),   32'd1);
    chk("rst_ack",      32'(ack),      32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tmo_err",  32'(tmo_err),  32'd0);
    mon_en = 1'b1;
  endtask

  task automatic wait_ack(input int exp_lat);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk16x);
      cyc++;
    end while (ack == 4'b0000 && cyc < 10);
    chk("ack_latency", 32'(cyc), 32'(exp_lat));
  endtask

  // One transfer: expect a grant, then play the transmitter's busy pulse.
  task automatic xfer(input logic [2:0] id, input logic [7:0] data, input int lag,
                      input int blen, input logic [3:0] drop, input logic [3:0] raise,
                      input bit toggle);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
    wait_ack(1);
    req = req & ~drop;
    if (lag == 0) begin
      tx_busy = 1'b1;
    end else begin
      repeat (lag) @(negedge clk16x);
      tx_busy = 1'b1;
    end
    for (int i = 0; i < blen; i++) begin
      @(negedge clk16x);
      if (i == blen / 2) req = req | raise;
      if (toggle) begin
        req_data = ~req_data;
        chk("tx_data_hold", 32'(tx_data), 32'(data));
      end
    end
    tx_busy = 1'b0;
    @(negedge clk16x);
    chk("busy_after_done", 32'(busy),   32'd0);
    chk("wrn_idle",        32'(tx_wrn), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[7];
    logic [7:0] rr_b[4];
    exp_t       e;
    int         cnt;

    vt[0] = '{4'b0100, 32'h44A53311, 3'd2, 8'hA5, 1, 20, 1'b0};
    vt[1] = '{4'b1001, 32'hF00F55AA, 3'd3, 8'hF0, 0, 4,  1'b0};
    vt[2] = '{4'b1001, 32'h12345678, 3'd0, 8'h78, 2, 3,  1'b0};
    vt[3] = '{4'b0110, 32'h9ABCDE01, 3'd1, 8'hDE, 1, 5,  1'b1};
    vt[4] = '{4'b1111, 32'h80402010, 3'd2, 8'h40, 0, 3,  1'b0};
    vt[5] = '{4'b0001, 32'h000000FF, 3'd0, 8'hFF, 1, 4,  1'b1};
    vt[6] = '{4'b1000, 32'hC3000000, 3'd3, 8'hC3, 3, 3,  1'b0};
    rr_b  = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    clr      = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    tx_busy  = 1'b0;

    do_reset();

    // Vector table: single requests and mixed request patterns.
    for (int i = 0; i < 7; i++) begin
      req_data = vt[i].word;
      req      = vt[i].req;
      xfer(vt[i].id, vt[i].data, vt[i].lag, vt[i].blen, vt[i].req, 4'b0000, vt[i].toggle);
    end

    // All requesters held high: grants rotate from 0 after reset.
    do_reset();
    req_data = 32'hD3C2B1A0;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      xfer(3'(k % 4), rr_b[k % 4], 0, 10, (k == 4) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0);
    end

    // Fairness: requester 3 raised while 0 is transmitting wins before 0 again.
    do_reset();
    req_data = 32'hD3C2B1A0;
    req      = 4'b0001;
    xfer(3'd0, 8'hA0, 1, 6, 4'b0000, 4'b1000, 1'b0);
    xfer(3'd3, 8'hD3, 1, 4, 4'b1000, 4'b0000, 1'b0);
    xfer(3'd0, 8'hA0, 1, 4, 4'b0001, 4'b0000, 1'b0);

    // Reset in WAIT_DONE with the transmitter still busy.
    req_data = 32'h00A50000;
    e.id     = 3'd2;
    e.data   = 8'hA5;
    sb.push_back(e);
    req = 4'b0100;
    wait_ack(1);
    req     = 4'b0000;
    tx_busy = 1'b1;
    repeat (3) @(negedge clk16x);
    chk("mid_busy_before_clr", 32'(busy), 32'd1);
    clr = 1'b1;
    @(negedge clk16x);
    chk("mid_clr_busy",     32'(busy),     32'd0);
    chk("mid_clr_tx_wrn",   32'(tx_wrn),   32'd1);
    chk("mid_clr_grant_id", 32'(grant_id), 32'd0);
    chk("mid_clr_tx_data",  32'(tx_data),  32'd0);
    clr      = 1'b0;
    tx_busy  = 1'b0;
    req_data = 32'h5A00003C;
    req      = 4'b1001;
    xfer(3'd0, 8'h3C, 1, 3, 4'b1001, 4'b0000, 1'b0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Transmitter never starts: watchdog returns to IDLE and sets the sticky flag.
    req_data = 32'h00007700;
    e.id     = 3'd1;
    e.data   = 8'h77;
    sb.push_back(e);
    req = 4'b0010;
    wait_ack(1);
    req = 4'b0000;
    cnt = 0;
    do begin
      @(negedge clk16x);
      cnt++;
    end while (busy && cnt < 40);
    chk("tmo_cycles", 32'(cnt), 32'(TMO + 1));
    chk("tmo_err_set", 32'(tmo_err), 32'd1);
    req_data = 32'h000000E7;
    req      = 4'b0001;
    xfer(3'd0, 8'hE7, 1, 3, 4'b0001, 4'b0000, 1'b0);
    chk("tmo_err_sticky", 32'(tmo_err), 32'd1);
    do_reset();
`else
    cnt = 0;
    chk("tmo_err_tied", 32'(tmo_err), 32'(cnt));
`endif

    repeat (3) @(negedge clk16x);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
